// File: rtl/channel_accum_gather.sv
// Channel accumulation and requantisation per lane, with a per-kernel result FIFO.
// A serializer streams the result to the feature writer one lane word per handshake.
module channel_accum_gather #(
  parameter int LANES       = 4,
  parameter int IN_WIDTH    = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int OUT_WIDTH   = 8,
  parameter int MAX_CHANNEL = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter int CH_W        = $clog2(MAX_CHANNEL + 1),
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cfg_start,
  input  logic [CH_W-1:0]           i_cfg_n_channel,
  input  logic [15:0]               i_cfg_n_kernel,
  input  logic [4:0]                i_cfg_shift,
  input  logic                      i_cfg_relu,
  input  logic                      i_cfg_sat,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [LANES*IN_WIDTH-1:0] i_in_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [OUT_WIDTH-1:0]      o_out_data,
  output logic [LW-1:0]             o_out_lane,
  output logic                      o_out_last,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err_cfg
);
  // state    | meaning
  // S_IDLE   | waiting for a legal start pulse
  // S_ACCUM  | summing input beats of the current kernel
  // S_COMMIT | requantise the sums and push them as one FIFO entry
  // S_DRAIN  | all kernels pushed; waiting for the output stream to empty
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COMMIT, S_DRAIN} state_t;

  localparam int EW = LANES * OUT_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  state_t                      state_q, state_d;
  logic [CH_W-1:0]             n_channel_q, ch_cnt_q, ch_cnt_d;
  logic [15:0]                 n_kernel_q, k_cnt_q, k_cnt_d;
  logic [4:0]                  shift_q;
  logic                        relu_q, sat_q, err_cfg_q;
  logic signed [ACC_WIDTH-1:0] acc_q [LANES];
  logic signed [ACC_WIDTH-1:0] acc_d [LANES];

  logic [EW:0]                 fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic [EW-1:0]               ser_data_q;
  logic [LW-1:0]               ser_lane_q;
  logic                        ser_valid_q, ser_last_q;

  logic                        cfg_ok, in_hs, out_hs, ser_free, push, pop, start_ok;
  logic [EW-1:0]               commit_word;

  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc,
                                                   input logic [4:0] sh,
                                                   input logic relu, input logic sat);
    logic signed [ACC_WIDTH-1:0] v;
    v = acc >>> sh;
    if (relu && v < 0) v = '0;
    if (sat) begin
      if (v > OUT_MAX) v = OUT_MAX;
      else if (v < OUT_MIN) v = OUT_MIN;
    end
    return v[OUT_WIDTH-1:0];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    cfg_ok     = (i_cfg_n_channel != '0) && (i_cfg_n_channel <= CH_W'(MAX_CHANNEL)) &&
                 (i_cfg_n_kernel != '0);
    start_ok   = (state_q == S_IDLE) && i_cfg_start && cfg_ok;
    o_in_ready = (state_q == S_ACCUM) && (count_q < CW'(FIFO_DEPTH));
    in_hs      = i_in_valid && o_in_ready;
    out_hs     = ser_valid_q && i_out_ready;
    // The serializer can take a new entry in the same cycle it hands off its last lane.
    ser_free   = !ser_valid_q || (out_hs && ser_lane_q == LW'(LANES - 1));
    pop        = (count_q != '0) && ser_free;
    push       = (state_q == S_COMMIT);
    commit_word = '0;
    for (int k = 0; k < LANES; k++)
      commit_word[k*OUT_WIDTH +: OUT_WIDTH] = requant(acc_q[k], shift_q, relu_q, sat_q);
  end

  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    k_cnt_d  = k_cnt_q;
    acc_d    = acc_q;
    o_done   = 1'b0;
    case (state_q)
      S_IDLE: if (start_ok) begin
        state_d  = S_ACCUM;
        ch_cnt_d = '0;
        k_cnt_d  = '0;
        for (int k = 0; k < LANES; k++) acc_d[k] = '0;
      end
      S_ACCUM: if (in_hs) begin
        for (int k = 0; k < LANES; k++)
          acc_d[k] = acc_q[k] + ACC_WIDTH'($signed(i_in_data[k*IN_WIDTH +: IN_WIDTH]));
        ch_cnt_d = ch_cnt_q + CH_W'(1);
        if (ch_cnt_q == n_channel_q - CH_W'(1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        for (int k = 0; k < LANES; k++) acc_d[k] = '0;
        ch_cnt_d = '0;
        k_cnt_d  = k_cnt_q + 16'd1;
        state_d  = (k_cnt_q == n_kernel_q - 16'd1) ? S_DRAIN : S_ACCUM;
      end
      S_DRAIN: if (count_q == '0 && !ser_valid_q) begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ch_cnt_q    <= '0;
      k_cnt_q     <= '0;
      n_channel_q <= '0;
      n_kernel_q  <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      sat_q       <= 1'b0;
      err_cfg_q   <= 1'b0;
      for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      k_cnt_q   <= k_cnt_d;
      err_cfg_q <= (state_q == S_IDLE) && i_cfg_start && !cfg_ok;
      for (int k = 0; k < LANES; k++) acc_q[k] <= acc_d[k];
      if (start_ok) begin
        n_channel_q <= i_cfg_n_channel;
        n_kernel_q  <= i_cfg_n_kernel;
        shift_q     <= i_cfg_shift;
        relu_q      <= i_cfg_relu;
        sat_q       <= i_cfg_sat;
      end
    end
  end

  // Each entry carries a flag marking the job's final kernel alongside the lane words.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {(k_cnt_q == n_kernel_q - 16'd1), commit_word};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      ser_lane_q  <= '0;
      ser_data_q  <= '0;
    end else if (pop) begin
      {ser_last_q, ser_data_q} <= fifo_mem_q[rd_ptr_q];
      ser_valid_q <= 1'b1;
      ser_lane_q  <= '0;
    end else if (out_hs) begin
      if (ser_lane_q == LW'(LANES - 1)) ser_valid_q <= 1'b0;
      else ser_lane_q <= ser_lane_q + LW'(1);
    end
  end

  always_comb begin
    o_out_data = '0;
    for (int k = 0; k < LANES; k++)
      if (ser_lane_q == LW'(k)) o_out_data = ser_data_q[k*OUT_WIDTH +: OUT_WIDTH];
  end

  assign o_out_valid = ser_valid_q;
  assign o_out_lane  = ser_lane_q;
  assign o_out_last  = ser_valid_q && ser_last_q && (ser_lane_q == LW'(LANES - 1));
  assign o_busy      = (state_q != S_IDLE);
  assign o_err_cfg   = err_cfg_q;

endmodule

// File: tb/tb_channel_accum_gather.sv
// Bench for channel_accum_gather: directed and random jobs checked against an arithmetic model.
module tb_channel_accum_gather;
  localparam int LANES       = 4;
  localparam int IN_WIDTH    = 8;
  localparam int ACC_WIDTH   = 24;
  localparam int OUT_WIDTH   = 8;
  localparam int MAX_CHANNEL = 64;
  localparam int FIFO_DEPTH  = 2;
  localparam int CH_W        = $clog2(MAX_CHANNEL + 1);

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] lane;
    logic       last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0;
  logic [CH_W-1:0] cfg_n_channel = '0;
  logic [15:0] cfg_n_kernel = '0;
  logic [4:0] cfg_shift = '0;
  logic cfg_relu = 1'b0, cfg_sat = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [LANES*IN_WIDTH-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_lane;
  logic out_last, busy, done, err_cfg;

  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0;
  int last_hs_cyc = -1, done_cyc = -1, first_valid_cyc = -1, last_acc_cyc = -1;
  int out_ready_mode = 0;
  word_t exp_q[$], obs_q[$];
  logic pv = 1'b0, pval = 1'b0;
  word_t pw;

  channel_accum_gather #(
    .LANES(LANES), .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .MAX_CHANNEL(MAX_CHANNEL), .FIFO_DEPTH(FIFO_DEPTH), .CH_W(CH_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_start(cfg_start), .i_cfg_n_channel(cfg_n_channel),
    .i_cfg_n_kernel(cfg_n_kernel), .i_cfg_shift(cfg_shift), .i_cfg_relu(cfg_relu),
    .i_cfg_sat(cfg_sat), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_lane(out_lane), .o_out_last(out_last), .o_busy(busy), .o_done(done),
    .o_err_cfg(err_cfg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected word: wrap to the accumulator width, shift, then ReLU and clamp or truncate.
  function automatic logic [7:0] model_q(input longint sum, input int sh, input bit relu,
                                         input bit sat);
    longint v;
    v = sum & 64'h0000_0000_00FF_FFFF;
    if (v >= 64'sd8388608) v = v - 64'sd16777216;
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (sat) begin
      if (v > 127) v = 127;
      if (v < -128) v = -128;
    end
    return v[7:0];
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (out_ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: collects accepted words, checks stall stability, counts pulses.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pv = 1'b0;
      pval = 1'b0;
    end else begin
      if (pv) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_word", {out_data, out_lane, out_last}, pw);
      end
      if (out_valid && !pval && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err_cfg) err_cnt++;
      if (out_valid && out_ready) begin
        obs_q.push_back({out_data, out_lane, out_last});
        last_hs_cyc = cyc;
      end
      pv = out_valid && !out_ready;
      pw = {out_data, out_lane, out_last};
      pval = out_valid;
    end
  end

  task automatic start_job(input int nch, input int nk, input int sh, input bit relu,
                           input bit sat);
    cfg_n_channel = CH_W'(nch);
    cfg_n_kernel = 16'(nk);
    cfg_shift = 5'(sh);
    cfg_relu = relu;
    cfg_sat = sat;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_beat();
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) last_acc_cyc = cyc;
      tick();
      n++;
    end
    chk("beat_accepted", acc, 1);
  endtask

  // mode 0: random lanes, 1: lane k = k+1, 2: {+100,-100,0,0}
  task automatic feed(input int nch, input int nk, input int sh, input bit relu, input bit sat,
                      input int mode, input int busy_at, input int bp_beat, input int gap_pct);
    longint sum [LANES];
    int beat = 0;
    int val;
    for (int k = 0; k < nk; k++) begin
      for (int l = 0; l < LANES; l++) sum[l] = 0;
      for (int c = 0; c < nch; c++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
          in_valid = 1'b0;
          tick();
        end
        for (int l = 0; l < LANES; l++) begin
          case (mode)
            1:       val = l + 1;
            2:       val = (l == 0) ? 100 : ((l == 1) ? -100 : 0);
            default: val = int'($urandom_range(0, 255)) - 128;
          endcase
          in_data[l*IN_WIDTH +: IN_WIDTH] = val[7:0];
          sum[l] += val;
        end
        if (beat == busy_at) begin
          cfg_start = 1'b1;
          cfg_n_channel = CH_W'(nch + 2);
          cfg_n_kernel = 16'(nk + 1);
          cfg_shift = 5'd7;
        end
        if (beat == bp_beat) begin
          in_valid = 1'b1;
          for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            tick();
          end
          out_ready_mode = 1;
        end
        send_beat();
        cfg_start = 1'b0;
        beat++;
      end
      for (int l = 0; l < LANES; l++)
        exp_q.push_back({model_q(sum[l], sh, relu, sat), 2'(l), (k == nk - 1 && l == LANES - 1)});
    end
    in_valid = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_nwords"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic job(input string tag, input int nch, input int nk, input int sh, input bit relu,
                     input bit sat, input int mode, input int busy_at, input int bp_beat,
                     input int gap_pct);
    int d0 = done_cnt;
    int n = 0;
    first_valid_cyc = -1;
    start_job(nch, nk, sh, relu, sat);
    feed(nch, nk, sh, relu, sat, mode, busy_at, bp_beat, gap_pct);
    while (done_cnt == d0 && n < 5000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    compare_out(tag);
  endtask

  task automatic illegal(input string tag, input int nch, input int nk);
    int e0 = err_cnt;
    start_job(nch, nk, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk({tag, "_err_pulse"}, err_cfg, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    tick();
    @(negedge clk);
    chk({tag, "_err_clear"}, err_cfg, 0);
    chk({tag, "_busy_after"}, busy, 0);
    tick();
    chk({tag, "_err_count"}, err_cnt - e0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", {in_ready, out_valid, out_data, out_lane, out_last, busy, done, err_cfg}, 0);
    rst = 1'b0;
    tick();

    out_ready_mode = 1;
    tick();
    job("sum3", 3, 1, 0, 1'b0, 1'b1, 1, -1, -1, 0);
    chk("valid_latency", first_valid_cyc, last_acc_cyc + 3);
    chk("done_after_last", done_cyc, last_hs_cyc + 1);

    job("sat", 4, 1, 0, 1'b0, 1'b1, 2, -1, -1, 0);
    job("relu", 4, 1, 0, 1'b1, 1'b1, 2, -1, -1, 0);
    job("trunc", 4, 1, 0, 1'b0, 1'b0, 2, -1, -1, 0);

    illegal("ill_nch0", 0, 1);
    illegal("ill_nk0", 3, 0);
    illegal("ill_nch_max1", MAX_CHANNEL + 1, 1);

    out_ready_mode = 0;
    tick();
    job("backpressure", 1, 4, 0, 1'b0, 1'b1, 0, -1, 3, 0);

    out_ready_mode = 0;
    tick();
    start_job(3, 2, 0, 1'b0, 1'b1);
    feed(3, 1, 0, 1'b0, 1'b1, 0, -1, -1, 0);
    in_data = '1;
    send_beat();
    send_beat();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midjob_reset_outputs",
        {in_ready, out_valid, out_data, out_lane, out_last, busy, done, err_cfg}, 0);
    rst = 1'b0;
    tick();
    obs_q.delete();
    exp_q.delete();
    out_ready_mode = 1;
    tick();
    job("after_reset", 3, 1, 0, 1'b0, 1'b1, 1, -1, -1, 0);

    out_ready_mode = 2;
    e0 = err_cnt;
    job("busy_start", 3, 2, 1, 1'b0, 1'b1, 0, 2, -1, 0);
    chk("busy_start_no_err", err_cnt, e0);

    for (int r = 0; r < 6; r++)
      job("rand", $urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 6),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, -1, -1, 25);

    job("maxch", MAX_CHANNEL, 1, 3, 1'b0, 1'b0, 0, -1, -1, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
